// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic matrix multiplier.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        DONE
    } state_e;

    // Width of the FEED step counter, which counts steps 0 .. 3N-3.
    function automatic int unsigned step_width(input int unsigned n);
        int unsigned w;
        w = $clog2(3 * n - 2);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mac_pe.sv
// One processing element of the output-stationary array: multiply-accumulate
// into a local accumulator and pass the operands east (a) and south (b).
// Build option SAT_OUT_EN: saturate the accumulator instead of wrapping, and
// raise 'sat' for every update that clipped.
module mac_pe import systolic_pkg::*; #(
    parameter int unsigned DW     = 5,
    parameter int unsigned OUT_W  = 12,
    parameter int unsigned SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [DW-1:0]    a_in,
    input  logic [DW-1:0]    b_in,
    output logic [DW-1:0]    a_out,
    output logic [DW-1:0]    b_out,
`ifdef SAT_OUT_EN
    output logic             sat,
`endif
    output logic [OUT_W-1:0] acc
);

    localparam int unsigned PW = 2 * DW;
    // Wide enough for any acc + product without losing the true sign/magnitude.
    localparam int unsigned XW = ((OUT_W > PW) ? OUT_W : PW) + 2;

    logic [PW-1:0]    a_ext;
    logic [PW-1:0]    b_ext;
    logic [PW-1:0]    prod;
    logic [XW-1:0]    prod_x;
    logic [XW-1:0]    acc_x;
    logic [XW-1:0]    sum_x;
    logic [OUT_W-1:0] acc_d;
`ifdef SAT_OUT_EN
    logic             sat_d;
`endif

    // Extend operands, multiply, accumulate at extended width, then wrap or clip.
    always_comb begin
        if (SIGNED != 0) begin
            a_ext  = {{DW{a_in[DW-1]}}, a_in};
            b_ext  = {{DW{b_in[DW-1]}}, b_in};
        end else begin
            a_ext  = {{DW{1'b0}}, a_in};
            b_ext  = {{DW{1'b0}}, b_in};
        end
        // Low PW bits of the extended product are the exact 2*DW-bit product.
        prod = a_ext * b_ext;
        if (SIGNED != 0) begin
            prod_x = {{(XW-PW){prod[PW-1]}}, prod};
            acc_x  = {{(XW-OUT_W){acc[OUT_W-1]}}, acc};
        end else begin
            prod_x = {{(XW-PW){1'b0}}, prod};
            acc_x  = {{(XW-OUT_W){1'b0}}, acc};
        end
        sum_x = acc_x + prod_x;
        acc_d = sum_x[OUT_W-1:0];
`ifdef SAT_OUT_EN
        sat_d = 1'b0;
        if (SIGNED != 0) begin
            // Signed overflow: the bits above the OUT_W sign bit disagree with it.
            if (sum_x[XW-1:OUT_W-1] != {(XW-OUT_W+1){sum_x[XW-1]}}) begin
                sat_d = 1'b1;
                acc_d = sum_x[XW-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                    : {1'b0, {(OUT_W-1){1'b1}}};
            end
        end else if (sum_x[XW-1:OUT_W] != '0) begin
            sat_d = 1'b1;
            acc_d = '1;
        end
`endif
    end

`ifdef SAT_OUT_EN
    // Report clipping only for updates that actually land in the accumulator.
    always_comb begin
        sat = en & sat_d;
    end
`endif

    // Pass registers and accumulator; clr starts a fresh job.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else if (clr) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else if (en) begin
            a_out <= a_in;
            b_out <= b_in;
            acc   <= acc_d;
        end
    end

endmodule

// File: rtl/systolic_matmul.sv
// NxN output-stationary systolic matrix multiplier, C = A x B, with a
// valid/ready handshake on the operand and result sides.
// Build option SAT_OUT_EN: saturating accumulators plus a sticky 'ovf' port.
module systolic_matmul import systolic_pkg::*; #(
    parameter int unsigned N      = 3,
    parameter int unsigned DW     = 5,
    parameter int unsigned OUT_W  = 2 * DW + $clog2(N),
    parameter int unsigned SIGNED = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*N*DW-1:0]    a_flat,
    input  logic [N*N*DW-1:0]    b_flat,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*N*OUT_W-1:0] c_flat,
    output logic                 busy
`ifdef SAT_OUT_EN
    ,
    output logic                 ovf
`endif
);

    localparam int unsigned SW = step_width(N);
    localparam logic [SW-1:0] LAST_STEP = SW'(3 * N - 3);

    state_e            state_q, state_d;
    logic [SW-1:0]     step_q;
    // Set once the last MAC step has been issued; one drain cycle follows
    // so the final sums are settled in the accumulators before DONE.
    logic              drain_q;
    logic [N*N*DW-1:0] a_q;
    logic [N*N*DW-1:0] b_q;
    logic              accept;
    logic              mac_en;

    logic [DW-1:0]     a_inj [N];
    logic [DW-1:0]     b_inj [N];
    logic [DW-1:0]     a_bus [N][N+1];
    logic [DW-1:0]     b_bus [N+1][N];
    logic [OUT_W-1:0]  acc   [N][N];
`ifdef SAT_OUT_EN
    logic [N*N-1:0]    sat_vec;
    logic              ovf_q;
`endif

    assign accept = in_valid & in_ready;
    assign mac_en = (state_q == FEED) & ~drain_q;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept)    state_d = FEED;
            FEED:    if (drain_q)   state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
    end

    // Step counter, drain flag and operand capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q  <= '0;
            drain_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
        end else if (accept) begin
            step_q  <= '0;
            drain_q <= 1'b0;
            a_q     <= a_flat;
            b_q     <= b_flat;
        end else if (mac_en) begin
            if (step_q == LAST_STEP) begin
                drain_q <= 1'b1;
            end else begin
                step_q  <= step_q + 1'b1;
            end
        end
    end

    // Skewed injection: row i gets A(i, s-i), column j gets B(s-j, j), else 0.
    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            int k;
            k        = int'(step_q) - i;
            a_inj[i] = '0;
            b_inj[i] = '0;
            if (k >= 0 && k < int'(N)) begin
                a_inj[i] = a_q[(i * int'(N) + k) * int'(DW) +: DW];
                b_inj[i] = b_q[(k * int'(N) + i) * int'(DW) +: DW];
            end
        end
    end

`ifdef SAT_OUT_EN
    // Sticky overflow flag for the current job.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (accept) begin
            ovf_q <= 1'b0;
        end else if (|sat_vec) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q;
`endif

    for (genvar r = 0; r < N; r++) begin : g_edge
        assign a_bus[r][0] = a_inj[r];
        assign b_bus[0][r] = b_inj[r];
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            mac_pe #(
                .DW     (DW),
                .OUT_W  (OUT_W),
                .SIGNED (SIGNED)
            ) u_pe (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (accept),
                .en    (mac_en),
                .a_in  (a_bus[i][j]),
                .b_in  (b_bus[i][j]),
                .a_out (a_bus[i][j+1]),
                .b_out (b_bus[i+1][j]),
`ifdef SAT_OUT_EN
                .sat   (sat_vec[i*N+j]),
`endif
                .acc   (acc[i][j])
            );

            assign c_flat[(i*N+j)*OUT_W +: OUT_W] = acc[i][j];
        end
    end

endmodule

// File: tb/tb_systolic_matmul.sv
// Directed bench for systolic_matmul: a default 3x3 unsigned instance and a
// 3x3 signed instance with OUT_W=8 for the wrap/saturation case.
module tb_systolic_matmul;

    localparam int N   = 3;
    localparam int DW  = 5;
    localparam int OW  = 12;
    localparam int OW2 = 8;

    typedef int mat_t [9];

    logic              clk;
    logic              rst_n;
    logic              in_valid, in_ready, out_valid, out_ready, busy;
    logic [N*N*DW-1:0] a_flat, b_flat;
    logic [N*N*OW-1:0] c_flat;
    logic              in_valid2, in_ready2, out_valid2, out_ready2, busy2;
    logic [N*N*DW-1:0] a_flat2, b_flat2;
    logic [N*N*OW2-1:0] c_flat2;
`ifdef SAT_OUT_EN
    logic              ovf1, ovf2;
`endif

    int n_cmp;
    int n_err;

    systolic_matmul #(.N(N), .DW(DW), .OUT_W(OW), .SIGNED(0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_flat    (a_flat),
        .b_flat    (b_flat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c_flat    (c_flat),
`ifdef SAT_OUT_EN
        .ovf       (ovf1),
`endif
        .busy      (busy)
    );

    systolic_matmul #(.N(N), .DW(DW), .OUT_W(OW2), .SIGNED(1)) dut_s (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .a_flat    (a_flat2),
        .b_flat    (b_flat2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .c_flat    (c_flat2),
`ifdef SAT_OUT_EN
        .ovf       (ovf2),
`endif
        .busy      (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N*N*DW-1:0] pack_op(input mat_t m);
        logic [N*N*DW-1:0] r;
        for (int k = 0; k < 9; k++) r[k*DW +: DW] = DW'(m[k]);
        return r;
    endfunction

    function automatic logic [N*N*OW-1:0] pack_c(input mat_t m);
        logic [N*N*OW-1:0] r;
        for (int k = 0; k < 9; k++) r[k*OW +: OW] = OW'(m[k]);
        return r;
    endfunction

    function automatic logic [N*N*OW2-1:0] pack_c2(input mat_t m);
        logic [N*N*OW2-1:0] r;
        for (int k = 0; k < 9; k++) r[k*OW2 +: OW2] = OW2'(m[k]);
        return r;
    endfunction

    // Present one job to the default DUT and wait (bounded) for out_valid.
    // edges: rising edges from accept to out_valid; bad: cycles with in_ready=1 or busy=0.
    task automatic run_job(input mat_t a, input mat_t b, output int edges, output int bad);
        @(negedge clk);
        a_flat   = pack_op(a);
        b_flat   = pack_op(b);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        edges = 0;
        bad   = 0;
        while (!out_valid && edges < 64) begin
            if (in_ready || !busy) bad++;
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic take_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (c_flat !== '0) begin n_err++; $display("FAIL reset_c_flat got %h want 0", c_flat); end
        n_cmp++; if (in_ready2 !== 1'b1) begin n_err++; $display("FAIL reset_in_ready2 got %b want 1", in_ready2); end
`ifdef SAT_OUT_EN
        n_cmp++; if (ovf1 !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", ovf1); end
`endif
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_identity();
        mat_t a = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
        mat_t b = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        int edges, bad;
        run_job(a, b, edges, bad);
        n_cmp++; if (edges !== 8) begin n_err++; $display("FAIL ident_latency got %0d want 8", edges); end
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL ident_ready_busy got %0d bad cycles want 0", bad); end
        n_cmp++; if (c_flat !== pack_c(b)) begin n_err++; $display("FAIL ident_c got %h want %h", c_flat, pack_c(b)); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL ident_done_ready got %b want 0", in_ready); end
        take_result();
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL ident_take got valid=%b ready=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_max();
        mat_t a = '{31, 31, 31, 31, 31, 31, 31, 31, 31};
        mat_t c = '{2883, 2883, 2883, 2883, 2883, 2883, 2883, 2883, 2883};
        int edges, bad;
        run_job(a, a, edges, bad);
        n_cmp++; if (c_flat !== pack_c(c)) begin n_err++; $display("FAIL max_c got %h want %h", c_flat, pack_c(c)); end
`ifdef SAT_OUT_EN
        n_cmp++; if (ovf1 !== 1'b0) begin n_err++; $display("FAIL max_ovf got %b want 0", ovf1); end
`endif
        take_result();
    endtask

    task automatic test_hold();
        mat_t a = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        mat_t c = '{30, 36, 42, 66, 81, 96, 102, 126, 150};
        mat_t z = '{9, 9, 9, 9, 9, 9, 9, 9, 9};
        int edges, bad, unstable;
        run_job(a, a, edges, bad);
        n_cmp++; if (c_flat !== pack_c(c)) begin n_err++; $display("FAIL hold_c got %h want %h", c_flat, pack_c(c)); end
        unstable = 0;
        a_flat = pack_op(z);
        b_flat = pack_op(z);
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            in_valid = t[0];
            if (!out_valid || in_ready || c_flat !== pack_c(c)) unstable++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++; if (unstable !== 0) begin n_err++; $display("FAIL hold_stable got %0d bad cycles want 0", unstable); end
        n_cmp++; if (out_valid !== 1'b1 || c_flat !== pack_c(c)) begin
            n_err++; $display("FAIL hold_end got valid=%b c=%h want 1/%h", out_valid, c_flat, pack_c(c));
        end
        take_result();
        n_cmp++; if (busy !== 1'b0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL hold_take got busy=%b ready=%b want 0/1", busy, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        mat_t a1 = '{31, 31, 31, 31, 31, 31, 31, 31, 31};
        mat_t a2 = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        mat_t id = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
        int edges, bad;
        run_job(a1, a1, edges, bad);
        take_result();
        run_job(a2, id, edges, bad);
        n_cmp++; if (edges !== 8) begin n_err++; $display("FAIL b2b_latency got %0d want 8", edges); end
        n_cmp++; if (c_flat !== pack_c(a2)) begin n_err++; $display("FAIL b2b_c got %h want %h", c_flat, pack_c(a2)); end
        take_result();
    endtask

    task automatic test_reset_midjob();
        mat_t a  = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        mat_t id = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
        mat_t d2 = '{2, 0, 0, 0, 2, 0, 0, 0, 2};
        mat_t c  = '{2, 4, 6, 8, 10, 12, 14, 16, 18};
        int edges, bad;
        @(negedge clk);
        a_flat   = pack_op(a);
        b_flat   = pack_op(id);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL midrst_ctrl got ready=%b busy=%b valid=%b want 1/0/0", in_ready, busy, out_valid);
        end
        n_cmp++; if (c_flat !== '0) begin n_err++; $display("FAIL midrst_c got %h want 0", c_flat); end
        @(negedge clk);
        rst_n = 1'b1;
        run_job(a, d2, edges, bad);
        n_cmp++; if (edges !== 8) begin n_err++; $display("FAIL midrst_latency got %0d want 8", edges); end
        n_cmp++; if (c_flat !== pack_c(c)) begin n_err++; $display("FAIL midrst_c2 got %h want %h", c_flat, pack_c(c)); end
        take_result();
    endtask

    task automatic test_signed();
        mat_t a = '{-16, -16, -16, -16, -16, -16, -16, -16, -16};
`ifdef SAT_OUT_EN
        mat_t c = '{127, 127, 127, 127, 127, 127, 127, 127, 127};
`else
        mat_t c = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
`endif
        int edges;
        @(negedge clk);
        a_flat2   = pack_op(a);
        b_flat2   = pack_op(a);
        in_valid2 = 1'b1;
        @(negedge clk);
        in_valid2 = 1'b0;
        edges = 0;
        while (!out_valid2 && edges < 64) begin
            @(negedge clk);
            edges++;
        end
        n_cmp++; if (edges !== 8) begin n_err++; $display("FAIL signed_latency got %0d want 8", edges); end
        n_cmp++; if (c_flat2 !== pack_c2(c)) begin n_err++; $display("FAIL signed_c got %h want %h", c_flat2, pack_c2(c)); end
`ifdef SAT_OUT_EN
        n_cmp++; if (ovf2 !== 1'b1) begin n_err++; $display("FAIL signed_ovf got %b want 1", ovf2); end
`endif
        @(negedge clk);
        out_ready2 = 1'b1;
        @(negedge clk);
        out_ready2 = 1'b0;
        n_cmp++; if (out_valid2 !== 1'b0 || in_ready2 !== 1'b1) begin
            n_err++; $display("FAIL signed_take got valid=%b ready=%b want 0/1", out_valid2, in_ready2);
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        a_flat     = '0;
        b_flat     = '0;
        in_valid2  = 1'b0;
        out_ready2 = 1'b0;
        a_flat2    = '0;
        b_flat2    = '0;
        test_reset();
        test_identity();
        test_max();
        test_hold();
        test_back_to_back();
        test_reset_midjob();
        test_signed();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
